// File: rtl/hnm_pkg.sv
// Shared types and helpers for the hit-notification map.
package hnm_pkg;

  localparam int unsigned DefRowBits    = 7;
  localparam int unsigned DefColBits    = 5;
  localparam int unsigned DefClearDelay = 4;

  // Map life cycle: sweep to zero, settle, then serve requests.
  typedef enum logic [1:0] {
    StClear = 2'd0,
    StDrain = 2'd1,
    StRun   = 2'd2
  } state_e;

  // An SSID is {row, col}; row selects the memory word, col the bit within it.
  function automatic logic [31:0] ssid_row(input logic [31:0] ssid, input int unsigned col_bits);
    return ssid >> col_bits;
  endfunction

  function automatic logic [31:0] ssid_col(input logic [31:0] ssid, input int unsigned col_bits);
    return ssid & ((32'd1 << col_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/hnm_bitmap_ram.sv
// Simple dual-port bitmap memory: one write port, one read port with a
// one-cycle synchronous read. A same-cycle read of the row being written
// returns the old contents. The array has no reset; the owner sweeps it.
module hnm_bitmap_ram #(
  parameter int unsigned AddrBits = 7,
  parameter int unsigned DataBits = 32
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [AddrBits-1:0] i_waddr,
  input  logic [DataBits-1:0] i_wdata,
  input  logic                i_re,
  input  logic [AddrBits-1:0] i_raddr,
  output logic [DataBits-1:0] o_rdata
);

  logic [DataBits-1:0] r_mem [2**AddrBits];

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

endmodule

// File: rtl/hnm_rmw_map.sv
// Hit-notification map: one bit per SSID, set by a two-stage read-modify-write
// with one-deep forwarding, queried with one-cycle latency, self-clearing by a
// row sweep, and counting how many distinct SSIDs have been set.
module hnm_rmw_map
  import hnm_pkg::*;
#(
  parameter int unsigned ROW_BITS    = DefRowBits,
  parameter int unsigned COL_BITS    = DefColBits,
  parameter int unsigned SSID_BITS   = ROW_BITS + COL_BITS,
  parameter int unsigned CLEAR_DELAY = DefClearDelay,
  parameter int unsigned CNT_BITS    = SSID_BITS + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_valid,
  input  logic [SSID_BITS-1:0] wr_ssid,
  output logic                 wr_ready,
  input  logic                 rd_valid,
  input  logic [SSID_BITS-1:0] rd_ssid,
  output logic                 rd_ready,
  output logic                 hit_valid,
  output logic                 hit,
  output logic [SSID_BITS-1:0] hit_ssid,
  output logic                 clearing,
  output logic [CNT_BITS-1:0]  n_hits
);

  localparam int unsigned NROWS   = 2**ROW_BITS;
  localparam int unsigned NCOLS   = 2**COL_BITS;
  localparam int unsigned DlyBits = (CLEAR_DELAY > 1) ? $clog2(CLEAR_DELAY) : 1;

  state_e               r_state;
  logic [ROW_BITS-1:0]  r_sweep_row;
  logic [DlyBits-1:0]   r_drain_cnt;
  logic [CNT_BITS-1:0]  r_n_hits;

  // Stage-1 op and the forwarded word from the previous stage-1 write.
  logic                 r_s1_valid;
  logic                 r_s1_wr;
  logic [SSID_BITS-1:0] r_s1_ssid;
  logic                 r_fwd_en;
  logic [NCOLS-1:0]     r_fwd_data;

  logic                 w_run;
  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_acc;
  logic [SSID_BITS-1:0] w_op_ssid;
  logic [ROW_BITS-1:0]  w_op_row;
  logic [ROW_BITS-1:0]  w_s1_row;
  logic [COL_BITS-1:0]  w_s1_col;
  logic [NCOLS-1:0]     w_rdata;
  logic [NCOLS-1:0]     w_s1_data;
  logic [NCOLS-1:0]     w_merged;
  logic                 w_s1_bit;
  logic                 w_s1_we;
  logic                 w_ram_we;
  logic [ROW_BITS-1:0]  w_ram_waddr;
  logic [NCOLS-1:0]     w_ram_wdata;

  // Request handshake: writes win, and a clear request blocks acceptance at once.
  always_comb begin
    w_run     = (r_state == StRun);
    wr_ready  = w_run & ~clear;
    rd_ready  = w_run & ~clear & ~wr_valid;
    w_wr_acc  = wr_valid & wr_ready;
    w_rd_acc  = rd_valid & rd_ready;
    w_acc     = w_wr_acc | w_rd_acc;
    w_op_ssid = w_wr_acc ? wr_ssid : rd_ssid;
    w_op_row  = ROW_BITS'(ssid_row(32'(w_op_ssid), COL_BITS));
  end

  // Stage-1 merge: take the forwarded word when the previous write hit this row.
  always_comb begin
    w_s1_row  = ROW_BITS'(ssid_row(32'(r_s1_ssid), COL_BITS));
    w_s1_col  = COL_BITS'(ssid_col(32'(r_s1_ssid), COL_BITS));
    w_s1_data = r_fwd_en ? r_fwd_data : w_rdata;
    w_s1_bit  = w_s1_data[w_s1_col];
    w_merged  = w_s1_data | (NCOLS'(1) << w_s1_col);
    w_s1_we   = r_s1_valid & r_s1_wr;
  end

  // Single write port: the sweep owns it outside RUN, write-back inside RUN.
  always_comb begin
    w_ram_we    = (r_state == StClear) | w_s1_we;
    w_ram_waddr = (r_state == StClear) ? r_sweep_row : w_s1_row;
    w_ram_wdata = (r_state == StClear) ? '0 : w_merged;
  end

  hnm_bitmap_ram #(
    .AddrBits (ROW_BITS),
    .DataBits (NCOLS)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_acc),
    .i_raddr (w_op_row),
    .o_rdata (w_rdata)
  );

  // Life-cycle FSM: sweep rows, wait out the settle delay, then run.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StClear;
      r_sweep_row <= '0;
      r_drain_cnt <= '0;
    end else if (clear) begin
      r_state     <= StClear;
      r_sweep_row <= '0;
      r_drain_cnt <= '0;
    end else begin
      unique case (r_state)
        StClear: begin
          r_sweep_row <= r_sweep_row + ROW_BITS'(1);
          if (r_sweep_row == ROW_BITS'(NROWS - 1)) begin
            r_state     <= StDrain;
            r_drain_cnt <= '0;
          end
        end
        StDrain: begin
          if (32'(r_drain_cnt) + 32'd1 >= CLEAR_DELAY) r_state <= StRun;
          else r_drain_cnt <= r_drain_cnt + DlyBits'(1);
        end
        StRun:   ;
        default: r_state <= StClear;
      endcase
    end
  end

  // Pipeline registers; forwarding is armed when the op entering stage 1
  // reads the row that the current stage-1 write is about to write back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_wr    <= 1'b0;
      r_s1_ssid  <= '0;
      r_fwd_en   <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_s1_valid <= w_acc;
      r_fwd_en   <= w_acc & w_s1_we & (w_s1_row == w_op_row);
      r_fwd_data <= w_merged;
      if (w_acc) begin
        r_s1_wr   <= w_wr_acc;
        r_s1_ssid <= w_op_ssid;
      end
    end
  end

  // Distinct-hit counter: count only 0->1 transitions, zero outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n_hits <= '0;
    end else if (!w_run || clear) begin
      r_n_hits <= '0;
    end else if (w_s1_we && !w_s1_bit && (r_n_hits != '1)) begin
      r_n_hits <= r_n_hits + CNT_BITS'(1);
    end
  end

  // Query result and status outputs.
  always_comb begin
    hit_valid = r_s1_valid & ~r_s1_wr;
    hit       = hit_valid & w_s1_bit;
    hit_ssid  = r_s1_ssid;
    clearing  = (r_state != StRun) & ~reset;
    n_hits    = r_n_hits;
  end

endmodule

// File: tb/tb_hnm_rmw_map.sv
// Directed bench for hnm_rmw_map with an 8x8 map (ROW_BITS=3, COL_BITS=3).
module tb_hnm_rmw_map;

  localparam int unsigned RB = 3;
  localparam int unsigned CB = 3;
  localparam int unsigned SB = RB + CB;
  localparam int unsigned NB = SB + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear = 1'b0;
  logic          wr_valid = 1'b0;
  logic [SB-1:0] wr_ssid = '0;
  logic          wr_ready;
  logic          rd_valid = 1'b0;
  logic [SB-1:0] rd_ssid = '0;
  logic          rd_ready;
  logic          hit_valid;
  logic          hit;
  logic [SB-1:0] hit_ssid;
  logic          clearing;
  logic [NB-1:0] n_hits;

  int checks = 0;
  int errors = 0;

  hnm_rmw_map #(
    .ROW_BITS    (RB),
    .COL_BITS    (CB),
    .CLEAR_DELAY (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .wr_valid  (wr_valid),
    .wr_ssid   (wr_ssid),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_ssid   (rd_ssid),
    .rd_ready  (rd_ready),
    .hit_valid (hit_valid),
    .hit       (hit),
    .hit_ssid  (hit_ssid),
    .clearing  (clearing),
    .n_hits    (n_hits)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic [SB-1:0] ws;
    logic          rv;
    logic [SB-1:0] rs;
    logic          ewr;
    logic          erd;
    logic          ehv;
    logic          ehit;
    logic [SB-1:0] ehs;
    int            enh;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic wv, input logic [SB-1:0] ws, input logic rv,
                     input logic [SB-1:0] rs, input logic ewr, input logic erd,
                     input logic ehv, input logic ehit, input logic [SB-1:0] ehs,
                     input int enh);
    vec_t v;
    v.wv = wv; v.ws = ws; v.rv = rv; v.rs = rs;
    v.ewr = ewr; v.erd = erd; v.ehv = ehv; v.ehit = ehit; v.ehs = ehs; v.enh = enh;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs just after the rising edge.
  task automatic drive(input logic wv, input logic [SB-1:0] ws, input logic rv,
                       input logic [SB-1:0] rs, input logic clr);
    @(posedge clk);
    #1;
    wr_valid = wv; wr_ssid = ws; rd_valid = rv; rd_ssid = rs; clear = clr;
  endtask

  // Count clearing-high cycles until wr_ready rises; bounded.
  task automatic wait_ready(input string name, input int exp_cycles);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_ready) begin
        done = 1'b1;
        break;
      end
      if (clearing) n++;
    end
    chk({name, "_ready_seen"}, 32'(done), 32'd1);
    chk({name, "_clear_cycles"}, 32'(n), 32'(exp_cycles));
    chk({name, "_nhits"}, 32'(n_hits), 32'd0);
  endtask

  task automatic expect_hit(input string name, input logic e_hit, input logic [SB-1:0] e_ssid);
    chk({name, "_hv"}, 32'(hit_valid), 32'd1);
    chk({name, "_hit"}, 32'(hit), 32'(e_hit));
    chk({name, "_ssid"}, 32'(hit_ssid), 32'(e_ssid));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    // wv ws rv rs | wr_ready rd_ready hit_valid hit hit_ssid n_hits (observed that cycle)
    add(0, 6'h00, 1, 6'h3F, 1, 1, 0, 0, 6'h00, 0);  // query empty map
    add(0, 6'h00, 0, 6'h00, 1, 1, 1, 0, 6'h3F, 0);
    add(1, 6'h15, 0, 6'h00, 1, 0, 0, 0, 6'h00, 0);  // write then read same SSID
    add(0, 6'h00, 1, 6'h15, 1, 1, 0, 0, 6'h00, 0);
    add(0, 6'h00, 0, 6'h00, 1, 1, 1, 1, 6'h15, 1);
    add(1, 6'h10, 0, 6'h00, 1, 0, 0, 0, 6'h00, 1);  // row 2 back-to-back
    add(1, 6'h11, 0, 6'h00, 1, 0, 0, 0, 6'h00, 1);
    add(1, 6'h10, 0, 6'h00, 1, 0, 0, 0, 6'h00, 2);
    add(0, 6'h00, 1, 6'h12, 1, 1, 0, 0, 6'h00, 3);
    add(0, 6'h00, 0, 6'h00, 1, 1, 1, 0, 6'h12, 3);  // duplicate 0x10 not counted
    add(0, 6'h00, 1, 6'h11, 1, 1, 0, 0, 6'h00, 3);
    add(0, 6'h00, 1, 6'h15, 1, 1, 1, 1, 6'h11, 3);
    add(0, 6'h00, 0, 6'h00, 1, 1, 1, 1, 6'h15, 3);
    add(1, 6'h20, 1, 6'h3F, 1, 0, 0, 0, 6'h00, 3);  // write priority over read
    add(1, 6'h21, 1, 6'h3F, 1, 0, 0, 0, 6'h00, 3);
    add(1, 6'h22, 1, 6'h3F, 1, 0, 0, 0, 6'h00, 4);
    add(0, 6'h00, 1, 6'h3F, 1, 1, 0, 0, 6'h00, 5);
    add(0, 6'h00, 0, 6'h00, 1, 1, 1, 0, 6'h3F, 6);
    add(0, 6'h00, 0, 6'h00, 1, 1, 0, 0, 6'h00, 6);

    // Reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_wr_ready", 32'(wr_ready), 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_hit_valid", 32'(hit_valid), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_hit_ssid", 32'(hit_ssid), 0);
    chk("rst_n_hits", 32'(n_hits), 0);
    chk("rst_clearing", 32'(clearing), 0);
    reset = 1'b0;
    wait_ready("init", 12);
    chk("run_clearing", 32'(clearing), 0);

    // Table-driven main function.
    foreach (vecs[i]) begin
      drive(vecs[i].wv, vecs[i].ws, vecs[i].rv, vecs[i].rs, 1'b0);
      @(negedge clk);
      chk($sformatf("v%0d_wr_ready", i), 32'(wr_ready), 32'(vecs[i].ewr));
      chk($sformatf("v%0d_rd_ready", i), 32'(rd_ready), 32'(vecs[i].erd));
      chk($sformatf("v%0d_hit_valid", i), 32'(hit_valid), 32'(vecs[i].ehv));
      chk($sformatf("v%0d_n_hits", i), 32'(n_hits), 32'(vecs[i].enh));
      if (vecs[i].ehv) begin
        chk($sformatf("v%0d_hit", i), 32'(hit), 32'(vecs[i].ehit));
        chk($sformatf("v%0d_hit_ssid", i), 32'(hit_ssid), 32'(vecs[i].ehs));
      end
    end

    // Clear request, then restart mid-sweep.
    drive(1, 6'h07, 0, 6'h00, 0);
    drive(1, 6'h38, 0, 6'h00, 0);
    drive(0, 6'h00, 0, 6'h00, 0);
    drive(0, 6'h00, 0, 6'h00, 0);
    @(negedge clk);
    chk("pre_clear_n_hits", 32'(n_hits), 8);
    drive(1, 6'h01, 1, 6'h07, 1);
    @(negedge clk);
    chk("clr_wr_ready", 32'(wr_ready), 0);
    chk("clr_rd_ready", 32'(rd_ready), 0);
    chk("clr_clearing", 32'(clearing), 0);
    drive(0, 6'h00, 0, 6'h00, 0);
    @(negedge clk);
    chk("sweep_clearing", 32'(clearing), 1);
    chk("sweep_n_hits", 32'(n_hits), 0);
    chk("sweep_wr_ready", 32'(wr_ready), 0);
    repeat (3) drive(0, 6'h00, 0, 6'h00, 0);
    drive(0, 6'h00, 0, 6'h00, 1);  // sweep is on row 4 here
    drive(0, 6'h00, 0, 6'h00, 0);
    wait_ready("restart", 12);
    drive(0, 6'h00, 1, 6'h07, 0);
    drive(0, 6'h00, 1, 6'h38, 0);
    @(negedge clk);
    expect_hit("clr_q07", 1'b0, 6'h07);
    drive(0, 6'h00, 1, 6'h01, 0);
    @(negedge clk);
    expect_hit("clr_q38", 1'b0, 6'h38);
    drive(0, 6'h00, 0, 6'h00, 0);
    @(negedge clk);
    expect_hit("clr_q01", 1'b0, 6'h01);

    // Reset during DRAIN with a write pending.
    drive(0, 6'h00, 0, 6'h00, 1);
    drive(1, 6'h2A, 0, 6'h00, 0);
    repeat (9) @(negedge clk);
    chk("drain_clearing", 32'(clearing), 1);
    chk("drain_wr_ready", 32'(wr_ready), 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_wr_ready", 32'(wr_ready), 0);
    chk("mid_rst_rd_ready", 32'(rd_ready), 0);
    chk("mid_rst_hit_valid", 32'(hit_valid), 0);
    chk("mid_rst_hit", 32'(hit), 0);
    chk("mid_rst_n_hits", 32'(n_hits), 0);
    chk("mid_rst_clearing", 32'(clearing), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_valid = 1'b0;
    wait_ready("post_rst", 12);
    drive(0, 6'h00, 1, 6'h2A, 0);
    drive(0, 6'h00, 0, 6'h00, 0);
    @(negedge clk);
    expect_hit("lost_wr", 1'b0, 6'h2A);
    chk("lost_wr_n_hits", 32'(n_hits), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
